// File: rtl/hash_msg_padder.sv
// hash_msg_padder: Merkle-Damgard padder in front of the hash core.
// Takes a byte-packed 32-bit message stream and emits padded 512-bit chunks
// one word per beat, with the 0x80 marker, zero fill and the 64-bit length.
// Optional feature: define HASH_PADDER_MD5_EN to support MD5, which emits
// byte-swapped data words and a little-endian length. Without it MD5 is
// rejected like the reserved opcode.
module hash_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  opcode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [2:0]  in_nbytes,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [3:0]  out_idx,
    output logic [1:0]  cwe_end,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, FEED, PAD, LEN} state_t;

    localparam logic [1:0] OP_SHA1      = 2'b01;
    localparam logic [1:0] OP_SHA256    = 2'b10;
    localparam logic [1:0] CWE_WAIT     = 2'b00;
    localparam logic [1:0] CWE_CONTINUE = 2'b01;
    localparam logic [1:0] CWE_FINISH   = 2'b10;

    state_t           state;
    logic [LEN_W-1:0] bit_len;
    logic [3:0]       wr_idx;
    logic             pend_marker;
    logic             out_final;

    logic             load_ok;
    logic             hs;
    logic [2:0]       nb;
    logic [5:0]       add_bits;
    logic [31:0]      feed_word;
    logic [63:0]      len64;
    logic             opcode_ok;
    logic             is_md5;
    logic [31:0]      data_fmt;
    logic [31:0]      marker_fmt;

    assign load_ok  = !out_valid || out_ready;
    assign hs       = out_valid && out_ready;
    assign in_ready = (state == FEED) && load_ok;
    assign nb       = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
    assign add_bits = in_last ? {nb, 3'b000} : 6'd32;

`ifdef HASH_PADDER_MD5_EN
    localparam logic [1:0] OP_MD5 = 2'b00;

    logic [1:0] op;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign is_md5     = (op == OP_MD5);
    assign opcode_ok  = (opcode == OP_MD5) || (opcode == OP_SHA1) || (opcode == OP_SHA256);
    assign data_fmt   = is_md5 ? bswap(feed_word) : feed_word;
    assign marker_fmt = is_md5 ? 32'h0000_0080 : 32'h8000_0000;
`else
    assign is_md5     = 1'b0;
    assign opcode_ok  = (opcode == OP_SHA1) || (opcode == OP_SHA256);
    assign data_fmt   = feed_word;
    assign marker_fmt = 32'h8000_0000;
`endif

    // Splice the 0x80 marker into the final word right after its valid bytes
    always_comb begin
        feed_word = in_data;
        if (in_last) begin
            case (nb)
                3'd0:    feed_word = 32'h8000_0000;
                3'd1:    feed_word = {in_data[31:24], 24'h80_0000};
                3'd2:    feed_word = {in_data[31:16], 16'h8000};
                3'd3:    feed_word = {in_data[31:8], 8'h80};
                default: feed_word = in_data;
            endcase
        end
    end

    // Widen the bit-length counter to the 64-bit length field, upper bits zero
    always_comb begin
        len64 = '0;
        len64[LEN_W-1:0] = bit_len;
    end

    // Control FSM plus the single output register stage and chunk signalling
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_len     <= '0;
            wr_idx      <= '0;
            pend_marker <= 1'b0;
            out_final   <= 1'b0;
            out_valid   <= 1'b0;
            out_word    <= '0;
            out_idx     <= '0;
            cwe_end     <= CWE_WAIT;
            busy        <= 1'b0;
            err         <= 1'b0;
`ifdef HASH_PADDER_MD5_EN
            op          <= OP_SHA256;
`endif
        end else begin
            err     <= 1'b0;
            cwe_end <= CWE_WAIT;

            if (hs) begin
                out_valid <= 1'b0;
                if (out_idx == 4'd15) begin
                    if (out_final) begin
                        cwe_end <= CWE_FINISH;
                        busy    <= 1'b0;
                    end else begin
                        cwe_end <= CWE_CONTINUE;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (start && !busy) begin
                        if (opcode_ok) begin
`ifdef HASH_PADDER_MD5_EN
                            op <= opcode;
`endif
                            bit_len     <= '0;
                            wr_idx      <= '0;
                            pend_marker <= 1'b0;
                            busy        <= 1'b1;
                            state       <= FEED;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                FEED: begin
                    if (in_valid && in_ready) begin
                        out_valid <= 1'b1;
                        out_word  <= data_fmt;
                        out_idx   <= wr_idx;
                        out_final <= 1'b0;
                        wr_idx    <= wr_idx + 4'd1;
                        bit_len   <= bit_len + {{(LEN_W-6){1'b0}}, add_bits};
                        if (in_last) begin
                            pend_marker <= (nb == 3'd4);
                            if ((nb != 3'd4) && (wr_idx == 4'd13)) begin
                                state <= LEN;
                            end else begin
                                state <= PAD;
                            end
                        end
                    end
                end
                PAD: begin
                    if (load_ok) begin
                        out_valid   <= 1'b1;
                        out_word    <= pend_marker ? marker_fmt : 32'h0;
                        out_idx     <= wr_idx;
                        out_final   <= 1'b0;
                        pend_marker <= 1'b0;
                        wr_idx      <= wr_idx + 4'd1;
                        if (wr_idx == 4'd13) begin
                            state <= LEN;
                        end
                    end
                end
                LEN: begin
                    if (load_ok) begin
                        out_valid <= 1'b1;
                        out_idx   <= wr_idx;
                        wr_idx    <= wr_idx + 4'd1;
                        if (wr_idx == 4'd14) begin
                            out_word  <= is_md5 ? len64[31:0] : len64[63:32];
                            out_final <= 1'b0;
                        end else begin
                            out_word  <= is_md5 ? len64[63:32] : len64[31:0];
                            out_final <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_msg_padder.sv
// tb_hash_msg_padder: table-driven directed bench for hash_msg_padder.
// Each table entry describes a message and the full expected padded output;
// hand-written sequences cover backpressure, illegal starts, MD5 and reset.
module tb_hash_msg_padder;

    localparam logic [1:0] CWE_CONTINUE = 2'b01;
    localparam logic [1:0] CWE_FINISH   = 2'b10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  opcode;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [2:0]  in_nbytes;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [3:0]  out_idx;
    logic [1:0]  cwe_end;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    hash_msg_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .opcode    (opcode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_idx   (out_idx),
        .cwe_end   (cwe_end),
        .busy      (busy),
        .err       (err)
    );

    typedef struct {
        string            name;
        logic [1:0]       op;
        int               n_full;
        logic [31:0]      fill;
        logic [31:0]      last_data;
        logic [2:0]       nb;
        int               chunks;
        logic [31:0][31:0] exp;
    } vec_t;

    logic [31:0] cap_word[$];
    logic [3:0]  cap_idx[$];
    logic [36:0] stall_held[$];
    logic [36:0] stall_now[$];
    int          cont_cnt = 0;
    int          fin_cnt  = 0;
    int          err_cnt  = 0;
    logic        rand_ready = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;

    // Drive out_ready at the falling edge, then sample handshakes and pulses mid-cycle
    initial begin : monitor
        logic        stalled;
        logic [36:0] held;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #2;
            if (stalled) begin
                stall_held.push_back(held);
                stall_now.push_back({out_valid, out_idx, out_word});
            end
            if (out_valid && out_ready) begin
                cap_word.push_back(out_word);
                cap_idx.push_back(out_idx);
            end
            stalled = out_valid && !out_ready;
            held    = {1'b1, out_idx, out_word};
            if (cwe_end == CWE_CONTINUE) cont_cnt++;
            if (cwe_end == CWE_FINISH)   fin_cnt++;
            if (err) err_cnt++;
        end
    end

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [1:0] op, input int n_full,
                                input logic [31:0] fill, input logic [31:0] last_data,
                                input logic [2:0] nb, input int chunks);
        vec_t r;
        r.name      = name;
        r.op        = op;
        r.n_full    = n_full;
        r.fill      = fill;
        r.last_data = last_data;
        r.nb        = nb;
        r.chunks    = chunks;
        r.exp       = '0;
        return r;
    endfunction

    task automatic do_start(input logic [1:0] op);
        @(negedge clk);
        start  = 1'b1;
        opcode = op;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int t;
        t = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        in_nbytes = nb;
        #3;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            #3;
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL send_timeout: in_ready stayed 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        do_start(v.op);
        for (int i = 0; i < v.n_full; i++) send_word(v.fill, 1'b0, 3'd0);
        send_word(v.last_data, 1'b1, v.nb);
    endtask

    task automatic wait_finish(input string name, input int fbase);
        int t;
        t = 0;
        while (fin_cnt == fbase && t < 600) begin
            @(negedge clk);
            #3;
            t++;
        end
        repeat (3) @(negedge clk);
        #3;
        check_val({name, " finish_count"}, 64'(fin_cnt - fbase), 64'd1);
    endtask

    task automatic check_output(input vec_t v, input int wbase, input int cbase, input int ebase);
        int n_exp;
        n_exp = v.chunks * 16;
        check_val({v.name, " word_count"}, 64'(cap_word.size() - wbase), 64'(n_exp));
        for (int k = 0; k < n_exp; k++) begin
            if (wbase + k < cap_word.size()) begin
                check_val($sformatf("%s w%0d", v.name, k), 64'(cap_word[wbase + k]), 64'(v.exp[k]));
                check_val($sformatf("%s idx%0d", v.name, k), 64'(cap_idx[wbase + k]), 64'(k % 16));
            end
        end
        check_val({v.name, " continue_count"}, 64'(cont_cnt - cbase), 64'(v.chunks - 1));
        check_val({v.name, " err_count"}, 64'(err_cnt - ebase), 64'd0);
        check_val({v.name, " busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic run_vector(input vec_t v);
        int wbase, cbase, fbase, ebase;
        wbase = cap_word.size();
        cbase = cont_cnt;
        fbase = fin_cnt;
        ebase = err_cnt;
        apply_stimulus(v);
        wait_finish(v.name, fbase);
        check_output(v, wbase, cbase, ebase);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, " in_ready"},  64'(in_ready),  64'd0);
        check_val({tag, " out_valid"}, 64'(out_valid), 64'd0);
        check_val({tag, " out_word"},  64'(out_word),  64'd0);
        check_val({tag, " out_idx"},   64'(out_idx),   64'd0);
        check_val({tag, " cwe_end"},   64'(cwe_end),   64'd0);
        check_val({tag, " busy"},      64'(busy),      64'd0);
        check_val({tag, " err"},       64'(err),       64'd0);
    endtask

    // Main test sequence: build the vector table, run it, then the corner cases
    initial begin : main
        vec_t vecs[$];
        vec_t v;
        vec_t abc;
        int   wbase, cbase, fbase, ebase;

        reset_n   = 1'b0;
        start     = 1'b0;
        opcode    = 2'b00;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_nbytes = '0;

        v = mk("sha256_empty", 2'b10, 0, 32'h0, 32'h0, 3'd0, 1);
        v.exp[0] = 32'h8000_0000;
        vecs.push_back(v);

        v = mk("sha256_abc", 2'b10, 0, 32'h0, 32'h6162_6300, 3'd3, 1);
        v.exp[0]  = 32'h6162_6380;
        v.exp[15] = 32'h0000_0018;
        vecs.push_back(v);
        abc = v;

        v = mk("sha1_abc", 2'b01, 0, 32'h0, 32'h6162_6300, 3'd3, 1);
        v.exp[0]  = 32'h6162_6380;
        v.exp[15] = 32'h0000_0018;
        vecs.push_back(v);

        v = mk("sha1_56B", 2'b01, 13, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'd4, 2);
        for (int k = 0; k < 14; k++) v.exp[k] = 32'hA5A5_A5A5;
        v.exp[14] = 32'h8000_0000;
        v.exp[31] = 32'h0000_01C0;
        vecs.push_back(v);

        v = mk("sha256_5B", 2'b10, 1, 32'hA5A5_A5A5, 32'h1122_3344, 3'd1, 1);
        v.exp[0]  = 32'hA5A5_A5A5;
        v.exp[1]  = 32'h1180_0000;
        v.exp[15] = 32'h0000_0028;
        vecs.push_back(v);

        v = mk("sha256_nb7", 2'b10, 0, 32'h0, 32'hDEAD_BEEF, 3'd7, 1);
        v.exp[0]  = 32'hDEAD_BEEF;
        v.exp[1]  = 32'h8000_0000;
        v.exp[15] = 32'h0000_0020;
        vecs.push_back(v);

        v = mk("sha256_mark14", 2'b10, 14, 32'h0102_0304, 32'h0A0B_0C0D, 3'd2, 2);
        for (int k = 0; k < 14; k++) v.exp[k] = 32'h0102_0304;
        v.exp[14] = 32'h0A0B_8000;
        v.exp[31] = 32'h0000_01D0;
        vecs.push_back(v);

        v = mk("sha256_mark13", 2'b10, 12, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 3'd4, 1);
        for (int k = 0; k < 13; k++) v.exp[k] = 32'h5A5A_5A5A;
        v.exp[13] = 32'h8000_0000;
        v.exp[15] = 32'h0000_01A0;
        vecs.push_back(v);

`ifdef HASH_PADDER_MD5_EN
        v = mk("md5_abc", 2'b00, 0, 32'h0, 32'h6162_6300, 3'd3, 1);
        v.exp[0]  = 32'h8063_6261;
        v.exp[14] = 32'h0000_0018;
        vecs.push_back(v);
`endif

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vector(vecs[i]);

        // Backpressure: random out_ready, same output, no change while stalled
        rand_ready = 1'b1;
        v = abc;
        v.name = "bp_abc";
        run_vector(v);
        rand_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_val("bp stall_seen", 64'(stall_held.size() > 0), 64'd1);
        for (int i = 0; i < stall_held.size(); i++)
            check_val($sformatf("bp stall_hold%0d", i), 64'(stall_now[i]), 64'(stall_held[i]));

        // Reserved opcode in IDLE: one-cycle err, stays idle
        ebase = err_cnt;
        wbase = cap_word.size();
        do_start(2'b11);
        repeat (4) @(negedge clk);
        #3;
        check_val("illegal err_pulses", 64'(err_cnt - ebase), 64'd1);
        check_val("illegal busy", 64'(busy), 64'd0);
        check_val("illegal words", 64'(cap_word.size() - wbase), 64'd0);

        // Start while busy is ignored without err and does not disturb the message
        wbase = cap_word.size();
        cbase = cont_cnt;
        fbase = fin_cnt;
        ebase = err_cnt;
        do_start(2'b10);
        do_start(2'b11);
        do_start(2'b01);
        send_word(32'h6162_6300, 1'b1, 3'd3);
        v = abc;
        v.name = "busy_start";
        wait_finish(v.name, fbase);
        check_output(v, wbase, cbase, ebase);

`ifndef HASH_PADDER_MD5_EN
        // MD5 is not built in: it is rejected like the reserved opcode
        ebase = err_cnt;
        wbase = cap_word.size();
        do_start(2'b00);
        repeat (20) @(negedge clk);
        #3;
        check_val("md5_off err_pulses", 64'(err_cnt - ebase), 64'd1);
        check_val("md5_off busy", 64'(busy), 64'd0);
        check_val("md5_off in_ready", 64'(in_ready), 64'd0);
        check_val("md5_off words", 64'(cap_word.size() - wbase), 64'd0);
`endif

        // Reset mid-chunk at out_idx 7, then a fresh message must run normally
        fbase = fin_cnt;
        do_start(2'b10);
        for (int i = 0; i < 8; i++) send_word(32'h0101_0101 * (i + 1), 1'b0, 3'd0);
        check_val("midreset out_idx_before", 64'(out_idx), 64'd7);
        check_val("midreset busy_before", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check_val("midreset no_finish", 64'(fin_cnt - fbase), 64'd0);
        v = abc;
        v.name = "after_reset";
        run_vector(v);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/hash_msg_padder.md
# hash_msg_padder

Front-end producer for the hash core: accepts a message as a stream of 32-bit byte-packed words and emits fully padded 512-bit chunks, one 32-bit word per beat, in the word order the core expects for the selected opcode. It performs Merkle–Damgård padding: the 0x80 marker, zero fill, and the 64-bit bit-length. It also drives the core's `cwe_end` chunk signalling: `WAIT`, `CONTINUE`, `FINISH`. It sits between the host/DMA input buffer and the memory/hash control path.

## Interface
- `LEN_W`, default 64: width of the internal bit-length counter; bits above `LEN_W` in the length field are zero.
- `clk`, in, 1: clock. The block uses this single clock.
- `reset_n`, in, 1: reset, asynchronous assert, active-low.
- `start`, in, 1: begin a message. Sampled only in `IDLE`.
- `opcode`, in, 2: `MD5`=00, `SHA_1`=01, `SHA_256`=10, `OPCODE_RESERVE`=11. Latched on an accepted `start`.
- `in_valid`, in, 1: input word valid.
- `in_ready`, out, 1: input word accepted when `in_valid && in_ready`.
- `in_data`, in, 32: message bytes, first byte in `[31:24]`.
- `in_last`, in, 1: final message word.
- `in_nbytes`, in, 3: valid bytes in the last word, 0..4. Values above 4 are treated as 4. Ignored when `in_last`=0.
- `out_valid`, out, 1: chunk word valid.
- `out_ready`, in, 1: core accepts the word.
- `out_word`, out, 32: chunk word.
- `out_idx`, out, 4: word index 0..15 within the chunk.
- `cwe_end`, out, 2: one-cycle pulse, `CONTINUE`=01 or `FINISH`=10; otherwise `WAIT`=00.
- `busy`, out, 1: high from an accepted `start` until `FINISH` is issued.
- `err`, out, 1: one-cycle pulse when a start is rejected.

## Operation
- **State machine.** States are `IDLE`, `FEED`, `PAD`, `LEN`.
- **`IDLE`.**
  - An accepted `start` with a valid opcode latches the opcode, clears the byte count and word index, and goes to `FEED`.
  - A start with an invalid opcode pulses `err` and stays in `IDLE`.
- **`FEED`.**
  - Each accepted word adds 4 bytes to the count, or `in_nbytes` bytes on the last word, and is emitted.
  - On the last word with n<4, bytes n..3 are replaced by 0x80 followed by zeros. If n==4, the next emitted word is 0x80000000.
  - After the last word the block goes to `PAD`; no input is taken in `PAD` or `LEN`.
- **`PAD`.**
  - Emits the pending 0x80000000 word if required, then zero words until the next index would be 14.
  - If the marker lands at index 14 or 15, the block zero-fills to 15, ends the chunk, and zero-fills the new chunk to index 13.
- **`LEN`.** Emits index 14 and index 15, then the block returns to `IDLE`.
- **Length value.** L = byte count × 8, modulo 2^`LEN_W`.
- **Byte order.** Internal words are big-endian byte order.
  - `SHA_1` and `SHA_256`: data and pad words are emitted unchanged; word14 = L[63:32], word15 = L[31:0].
  - `MD5`: data and pad words are byte-swapped; word14 = L[31:0], word15 = L[63:32].
- **`out_idx`.** Increments on every output handshake and wraps 15→0.
- **`cwe_end` pulses.**
  - `CONTINUE`: on the handshake of word 15 of a non-final chunk.
  - `FINISH`: on the handshake of word 15 of the final chunk.
- **Start while busy.** A `start` while `busy` is ignored, with no `err`.
- **Reset mid-operation.** Reset drops any partial chunk; no `FINISH` is issued.

## Timing
- **Reset values.** `in_ready`=0, `out_valid`=0, `out_word`=0, `out_idx`=0, `cwe_end`=`WAIT`, `busy`=0, `err`=0, state `IDLE`.
- **Output register.** The output is a single register stage.
  - An input word accepted in cycle N appears on `out_word` in cycle N+1.
  - `out_valid`, `out_word` and `out_idx` hold stable while `out_ready`=0.
- **Input ready.** `in_ready` = (state==`FEED`) && (!`out_valid` || `out_ready`). It first rises in the cycle after the accepted `start`.
- **Throughput.** One word per cycle when `out_ready`=1. Pad and length words are produced back-to-back with no bubbles.
- **`cwe_end` and `busy` timing.** `cwe_end` is registered and asserts in the cycle after the word-15 handshake. `busy` falls in the same cycle as `FINISH`.
- **Back-to-back messages.** A new `start` is accepted in the cycle after `FINISH`.

## Configuration
- **`HASH_PADDER_MD5_EN` defined.** `MD5` is supported as described above.
- **`HASH_PADDER_MD5_EN` undefined.** The byte-swap logic is removed. `MD5` is rejected like `OPCODE_RESERVE`: `err` pulses and the block stays in `IDLE`.

## Test plan
- **SHA-256, empty message.** `start`, then one word with `in_last`=1 and `in_nbytes`=0 → 16 words: 0x80000000, then fourteen 0x00000000, then word15=0x00000000. `FINISH` once.
- **SHA-256, "abc".** `in_data`=0x61626300 with `in_nbytes`=3 → word0=0x61626380, words 1–14 = 0, word15=0x00000018, then `FINISH`.
- **MD5, "abc".** Same input → word0=0x80636261, word14=0x00000018, word15=0x00000000. Repeat with the macro undefined → `err` pulses and no output.
- **SHA-1, 56 bytes.** 14 full words of 0xA5A5A5A5, last with `in_nbytes`=4 → chunk 1: words 0–13 pass through, word14=0x80000000, word15=0, then `CONTINUE`. Chunk 2: zeros, word15=0x000001C0, then `FINISH`.
- **Backpressure.** "abc" SHA-256 with random `out_ready` (≈50 % duty) → identical 16-word sequence, and `out_word` never changes while stalled.
- **Reset and illegal starts.** Assert `reset_n`=0 at `out_idx`=7 → all outputs at reset values next cycle, and a fresh start is accepted. A `start` with `opcode`=11 → `err`=1 for one cycle and `busy` stays 0.
